// File: rtl/ddr3_app_tester.sv
// Self-checking traffic generator for the MIG native app interface: writes a
// seed-based incrementing pattern over an address range, reads it back and counts mismatches.
module ddr3_app_tester #(
   parameter int PAYLOAD_WIDTH = 64,
   parameter int ADDR_WIDTH    = 28,
   parameter int ADDR_STEP     = 8
) (
   input  logic                         i_sys_clk,
   input  logic                         i_sys_rst,
   input  logic                         i_start,
   input  logic                         i_init_done,
   input  logic [ADDR_WIDTH-1:0]        i_base_addr,
   input  logic [31:0]                  i_word_count,
   input  logic [31:0]                  i_seed,
   output logic                         o_busy,
   output logic                         o_done,
   output logic [31:0]                  o_err_count,
   output logic [ADDR_WIDTH-1:0]        o_first_err_addr,
   output logic [ADDR_WIDTH-1:0]        o_app_addr,
   output logic [2:0]                   o_app_cmd,
   output logic                         o_app_en,
   input  logic                         i_app_rdy,
   output logic [4*PAYLOAD_WIDTH-1:0]   o_app_wdf_data,
   output logic [4*PAYLOAD_WIDTH/8-1:0] o_app_wdf_mask,
   output logic                         o_app_wdf_wren,
   output logic                         o_app_wdf_end,
   input  logic                         i_app_wdf_rdy,
   input  logic [4*PAYLOAD_WIDTH-1:0]   i_app_rd_data,
   input  logic                         i_app_rd_data_valid
);
   localparam int DATA_W = 4*PAYLOAD_WIDTH;
   localparam int REP    = DATA_W/32;
   localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(ADDR_STEP);

   typedef enum logic [1:0] {IDLE, WRITE, READ, DONE_ST} state_t;

   state_t                r_state, w_nextState;
   logic [31:0]           r_count, r_wrIdx, r_rdIssued, r_rdRet, r_wrVal, r_retVal, r_errCount;
   logic [ADDR_WIDTH-1:0] r_base, r_appAddr, r_retAddr, r_firstErrAddr;
   logic [2:0]            r_appCmd;
   logic                  r_appEn, r_wren, r_done;

   logic w_accept, w_wordDone, w_lastWr, w_beat, w_lastBeat, w_mismatch;

   // A write word retires once each side is either already accepted or is being accepted now.
   assign w_accept   = (r_state == IDLE) && i_start && i_init_done;
   assign w_wordDone = (r_state == WRITE) && (!r_appEn || i_app_rdy) && (!r_wren || i_app_wdf_rdy);
   assign w_lastWr   = (r_wrIdx == r_count - 32'd1);
   assign w_beat     = (r_state == READ) && i_app_rd_data_valid;
   assign w_lastBeat = (r_rdRet == r_count - 32'd1);
   assign w_mismatch = (i_app_rd_data != {REP{r_retVal}});

   always_ff @(posedge i_sys_clk) begin
      if (i_sys_rst) r_state <= IDLE;
      else           r_state <= w_nextState;
   end

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE:    if (w_accept) w_nextState = (i_word_count == 32'd0) ? DONE_ST : WRITE;
         WRITE:   if (w_wordDone && w_lastWr) w_nextState = READ;
         READ:    if (w_beat && w_lastBeat) w_nextState = DONE_ST;
         DONE_ST: w_nextState = IDLE;
         default: w_nextState = IDLE;
      endcase
   end

   always_comb begin
      o_busy           = (r_state == WRITE) || (r_state == READ);
      o_done           = r_done;
      o_err_count      = r_errCount;
      o_first_err_addr = r_firstErrAddr;
      o_app_addr       = r_appAddr;
      o_app_cmd        = r_appCmd;
      o_app_en         = r_appEn;
      o_app_wdf_data   = {REP{r_wrVal}};
      o_app_wdf_mask   = '0;
      o_app_wdf_wren   = r_wren;
      o_app_wdf_end    = r_wren;
   end

   always_ff @(posedge i_sys_clk) begin
      if (i_sys_rst) begin
         r_count <= '0; r_wrIdx <= '0; r_rdIssued <= '0; r_rdRet <= '0;
         r_wrVal <= '0; r_retVal <= '0; r_errCount <= '0;
         r_base <= '0; r_appAddr <= '0; r_retAddr <= '0; r_firstErrAddr <= '0;
         r_appCmd <= 3'b000; r_appEn <= 1'b0; r_wren <= 1'b0; r_done <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_count        <= i_word_count;
                  r_base         <= i_base_addr;
                  r_done         <= 1'b0;
                  r_errCount     <= '0;
                  r_firstErrAddr <= '0;
                  r_wrIdx        <= '0;
                  r_rdIssued     <= '0;
                  r_rdRet        <= '0;
                  r_wrVal        <= i_seed;
                  r_retVal       <= i_seed;
                  r_retAddr      <= i_base_addr;
                  r_appAddr      <= i_base_addr;
                  r_appCmd       <= 3'b000;
                  r_appEn        <= (i_word_count != 32'd0);
                  r_wren         <= (i_word_count != 32'd0);
               end
            end
            WRITE: begin
               if (w_wordDone && w_lastWr) begin
                  r_appCmd  <= 3'b001;
                  r_appAddr <= r_base;
                  r_appEn   <= 1'b1;
                  r_wren    <= 1'b0;
               end else if (w_wordDone) begin
                  r_wrIdx   <= r_wrIdx + 32'd1;
                  r_wrVal   <= r_wrVal + 32'd1;
                  r_appAddr <= r_appAddr + STEP;
                  r_appEn   <= 1'b1;
                  r_wren    <= 1'b1;
               end else begin
                  if (r_appEn && i_app_rdy)    r_appEn <= 1'b0;
                  if (r_wren && i_app_wdf_rdy) r_wren  <= 1'b0;
               end
            end
            READ: begin
               if (r_appEn && i_app_rdy) begin
                  r_rdIssued <= r_rdIssued + 32'd1;
                  if (r_rdIssued == r_count - 32'd1) r_appEn <= 1'b0;
                  else                                r_appAddr <= r_appAddr + STEP;
               end
               // Returns arrive in command order, so the return counter alone names the expected word.
               if (w_beat) begin
                  r_rdRet   <= r_rdRet + 32'd1;
                  r_retVal  <= r_retVal + 32'd1;
                  r_retAddr <= r_retAddr + STEP;
                  if (w_mismatch) begin
                     if (r_errCount != 32'hFFFF_FFFF) r_errCount <= r_errCount + 32'd1;
                     if (r_errCount == 32'd0)         r_firstErrAddr <= r_retAddr;
                  end
               end
            end
            DONE_ST: begin
               r_done  <= 1'b1;
               r_appEn <= 1'b0;
               r_wren  <= 1'b0;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_ddr3_app_tester.sv
// Randomized bench for ddr3_app_tester: a behavioural MIG model with stalls,
// read latency and injectable corruption, checked against the pattern rules.
module tb_ddr3_app_tester;
   logic         sysClk = 1'b0;
   logic         sysRst, start, initDone;
   logic [27:0]  baseAddr;
   logic [31:0]  wordCount, seed;
   logic         busy, done;
   logic [31:0]  errCount;
   logic [27:0]  firstErrAddr, appAddr;
   logic [2:0]   appCmd;
   logic         appEn, appRdy, wdfWren, wdfEnd, wdfRdy, rdValid;
   logic [255:0] wdfData, rdData;
   logic [31:0]  wdfMask;

   ddr3_app_tester dut (
      .i_sys_clk(sysClk), .i_sys_rst(sysRst), .i_start(start), .i_init_done(initDone),
      .i_base_addr(baseAddr), .i_word_count(wordCount), .i_seed(seed),
      .o_busy(busy), .o_done(done), .o_err_count(errCount), .o_first_err_addr(firstErrAddr),
      .o_app_addr(appAddr), .o_app_cmd(appCmd), .o_app_en(appEn), .i_app_rdy(appRdy),
      .o_app_wdf_data(wdfData), .o_app_wdf_mask(wdfMask), .o_app_wdf_wren(wdfWren),
      .o_app_wdf_end(wdfEnd), .i_app_wdf_rdy(wdfRdy), .i_app_rd_data(rdData),
      .i_app_rd_data_valid(rdValid)
   );

   always #5 sysClk = ~sysClk;

   int total = 0;
   int bad   = 0;

   task automatic checkOutput(input string tag, input logic [255:0] observed, input logic [255:0] expected);
      total++;
      if (observed !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
      end
   endtask

   // MIG model state: everything happens on the falling edge, ahead of the DUT's rising edge.
   typedef struct {logic [27:0] addr; int unsigned due; int idx;} rdPend_t;
   logic [27:0]  wrCmdQ[$];
   logic [255:0] wrDataQ[$];
   logic [27:0]  rdCmdQ[$];
   rdPend_t      pendQ[$];
   logic [255:0] mem [logic [27:0]];
   int unsigned  cyc = 0;
   int           rdyPct = 100, wdfPct = 100, latency = 10, rdIdx = 0, wrPaired = 0;
   int           enSeen = 0, endBad = 0;
   logic [63:0]  corruptMask = '0;

   always @(negedge sysClk) begin
      rdPend_t p;
      logic [255:0] d;
      cyc++;
      appRdy = ($urandom_range(99) < rdyPct);
      wdfRdy = ($urandom_range(99) < wdfPct);
      if (appEn || wdfWren) enSeen++;
      if (wdfEnd !== wdfWren || wdfMask !== 32'd0) endBad++;
      if (appEn && appRdy) begin
         if (appCmd == 3'b000) wrCmdQ.push_back(appAddr);
         else begin
            rdCmdQ.push_back(appAddr);
            pendQ.push_back('{appAddr, cyc + latency, rdIdx});
            rdIdx++;
         end
      end
      if (wdfWren && wdfRdy) wrDataQ.push_back(wdfData);
      while (wrPaired < wrCmdQ.size() && wrPaired < wrDataQ.size()) begin
         mem[wrCmdQ[wrPaired]] = wrDataQ[wrPaired];
         wrPaired++;
      end
      rdValid = 1'b0;
      if (pendQ.size() > 0 && pendQ[0].due <= cyc) begin
         p = pendQ.pop_front();
         d = mem.exists(p.addr) ? mem[p.addr] : '0;
         if (p.idx < 64 && corruptMask[p.idx]) d[0] = ~d[0];
         rdData  = d;
         rdValid = 1'b1;
      end
   end

   function automatic logic [255:0] patWord(input logic [31:0] sd, input int i);
      return {8{sd + 32'(i)}};
   endfunction

   task automatic clearModel();
      wrCmdQ.delete(); wrDataQ.delete(); rdCmdQ.delete();
      wrPaired = 0; rdIdx = 0; enSeen = 0;
   endtask

   // One full test: start, optionally poke start/init_done while busy, wait, compare to the rules.
   task automatic applyStimulus(input logic [27:0] base, input int count, input logic [31:0] sd,
                                input logic [63:0] mask, input bit poke);
      int n;
      int expErr;
      logic [27:0] expFirst, a;
      bit found;
      clearModel();
      corruptMask = mask;
      baseAddr = base; wordCount = 32'(count); seed = sd; start = 1'b1;
      @(negedge sysClk);
      start = 1'b0;
      checkOutput("busyAfterStart", busy, 1);
      checkOutput("doneCleared", done, 0);
      if (poke) begin
         repeat (2) @(negedge sysClk);
         baseAddr = ~base; wordCount = 32'd5; seed = ~sd; start = 1'b1;
         @(negedge sysClk);
         start = 1'b0; initDone = 1'b0;
      end
      n = 0;
      while (!done && n < 20000) begin
         @(negedge sysClk);
         n++;
      end
      initDone = 1'b1;
      checkOutput("doneReached", done, 1);
      checkOutput("busyAtEnd", busy, 0);
      checkOutput("wrCmdCount", wrCmdQ.size(), count);
      checkOutput("wrDataCount", wrDataQ.size(), count);
      checkOutput("rdCmdCount", rdCmdQ.size(), count);
      expErr = 0; expFirst = '0; found = 1'b0;
      for (int i = 0; i < count; i++) begin
         a = base + 28'(i) * 28'd8;
         if (i < wrCmdQ.size())  checkOutput("wrAddr", wrCmdQ[i], a);
         if (i < wrDataQ.size()) checkOutput("wrData", wrDataQ[i], patWord(sd, i));
         if (i < rdCmdQ.size())  checkOutput("rdAddr", rdCmdQ[i], a);
         if (i < 64 && mask[i]) begin
            expErr++;
            if (!found) begin expFirst = a; found = 1'b1; end
         end
      end
      checkOutput("errCount", errCount, expErr);
      checkOutput("firstErrAddr", firstErrAddr, expFirst);
   endtask

   initial begin
      int n;
      logic [255:0] expVal;
      sysRst = 1'b1; start = 1'b0; initDone = 1'b1;
      baseAddr = '0; wordCount = '0; seed = '0;
      appRdy = 1'b1; wdfRdy = 1'b1; rdValid = 1'b0; rdData = '0;
      repeat (3) @(negedge sysClk);
      sysRst = 1'b0;
      @(negedge sysClk);
      checkOutput("rstBusy", busy, 0);
      checkOutput("rstDone", done, 0);
      checkOutput("rstErr", errCount, 0);
      checkOutput("rstFirst", firstErrAddr, 0);
      checkOutput("rstAppEn", appEn, 0);
      checkOutput("rstWren", wdfWren, 0);
      checkOutput("rstCmd", appCmd, 0);
      checkOutput("rstAddr", appAddr, 0);

      applyStimulus(28'h100, 4, 32'hA5A5_0000, 64'h0, 1'b0);
      expVal = {8{32'hA5A5_0003}};
      if (wrCmdQ.size() == 4) checkOutput("plan0Addr3", wrCmdQ[3], 28'h118);
      if (wrDataQ.size() == 4) checkOutput("plan0Data3", wrDataQ[3], expVal);

      applyStimulus(28'h0, 8, $urandom, 64'h04, 1'b0);
      checkOutput("oneErrFirst", firstErrAddr, 28'h10);
      applyStimulus(28'h0, 8, $urandom, 64'h24, 1'b0);
      checkOutput("twoErrCount", errCount, 2);

      rdyPct = 60; wdfPct = 60; latency = 3;
      applyStimulus(28'h2000, 64, $urandom, 64'h0, 1'b1);
      rdyPct = 100; wdfPct = 100; latency = 10;

      applyStimulus(28'hFFF_FFF8, 3, $urandom, 64'h0, 1'b0);
      if (rdCmdQ.size() == 3) checkOutput("wrapAddr1", rdCmdQ[1], 28'h000_0000);
      if (rdCmdQ.size() == 3) checkOutput("wrapAddr2", rdCmdQ[2], 28'h000_0008);

      // Zero-length test: done two cycles after start, never any traffic.
      clearModel();
      baseAddr = 28'h40; wordCount = 32'd0; seed = $urandom; start = 1'b1;
      @(negedge sysClk);
      start = 1'b0;
      checkOutput("zeroDoneEarly", done, 0);
      @(negedge sysClk);
      checkOutput("zeroDone", done, 1);
      repeat (3) @(negedge sysClk);
      checkOutput("zeroTraffic", enSeen, 0);

      // Start while init_done is low is ignored; done from the previous test stays.
      clearModel();
      initDone = 1'b0; wordCount = 32'd4; start = 1'b1;
      @(negedge sysClk);
      start = 1'b0;
      repeat (2) @(negedge sysClk);
      checkOutput("noInitBusy", busy, 0);
      checkOutput("noInitDone", done, 1);
      checkOutput("noInitTraffic", enSeen, 0);
      initDone = 1'b1;

      // Reset with reads in flight, then a clean rerun.
      clearModel();
      corruptMask = '0;
      baseAddr = 28'h800; wordCount = 32'd16; seed = $urandom; start = 1'b1;
      @(negedge sysClk);
      start = 1'b0;
      n = 0;
      while (rdCmdQ.size() < 3 && n < 1000) begin
         @(negedge sysClk);
         n++;
      end
      checkOutput("reachedRead", rdCmdQ.size() >= 3, 1);
      sysRst = 1'b1;
      @(negedge sysClk);
      checkOutput("midRstBusy", busy, 0);
      checkOutput("midRstDone", done, 0);
      checkOutput("midRstErr", errCount, 0);
      checkOutput("midRstAppEn", appEn, 0);
      sysRst = 1'b0;
      enSeen = 0;
      repeat (20) @(negedge sysClk);
      checkOutput("postRstQuiet", enSeen, 0);
      applyStimulus(28'h800, 16, $urandom, 64'h0, 1'b0);

      for (int r = 0; r < 4; r++) begin
         rdyPct = $urandom_range(100, 50); wdfPct = $urandom_range(100, 50);
         latency = $urandom_range(12, 1);
         applyStimulus(28'($urandom), $urandom_range(40, 1), $urandom, {$urandom, $urandom}, 1'b0);
      end

      checkOutput("wdfEndMask", endBad, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
